// File: rtl/lut_neuron_pkg.sv
// Shared constants and FSM state type for the LUT neuron array.
package lut_neuron_pkg;

  localparam int unsigned DEF_N_NEUR = 4;
  localparam int unsigned DEF_IN_W   = 8;
  localparam int unsigned DEF_OUT_W  = 1;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    CFG   = 2'd2
  } state_t;

  // Selector width that stays at least one bit wide for a single neuron.
  function automatic int unsigned sel_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lut_neuron_table.sv
// One writable 2**IN_W x OUT_W distributed table with asynchronous read.
// LUT_READBACK_EN adds a second asynchronous read port for configuration readback.
import lut_neuron_pkg::*;

module lut_neuron_table #(
  parameter int unsigned IN_W  = DEF_IN_W,
  parameter int unsigned OUT_W = DEF_OUT_W
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IN_W-1:0]  waddr,
  input  logic [OUT_W-1:0] wdata,
  input  logic [IN_W-1:0]  raddr,
  output logic [OUT_W-1:0] rdata
`ifdef LUT_READBACK_EN
  ,
  input  logic [IN_W-1:0]  rb_addr,
  output logic [OUT_W-1:0] rb_data
`endif
);

  // Contents deliberately survive reset.
  logic [OUT_W-1:0] mem [2**IN_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

`ifdef LUT_READBACK_EN
  assign rb_data = mem[rb_addr];
`endif

endmodule

// File: rtl/lut_neuron_array.sv
// N_NEUR independent LUT neurons behind a 2-stage valid/ready pipeline with a
// drain-then-configure table update window. LUT_READBACK_EN enables cfg_re/cfg_rdata.
import lut_neuron_pkg::*;

module lut_neuron_array #(
  parameter int unsigned N_NEUR = DEF_N_NEUR,
  parameter int unsigned IN_W   = DEF_IN_W,
  parameter int unsigned OUT_W  = DEF_OUT_W,
  localparam int unsigned NEUR_W = sel_w(N_NEUR)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [N_NEUR*IN_W-1:0]  s_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [N_NEUR*OUT_W-1:0] m_data,
  input  logic                    cfg_req,
  output logic                    cfg_gnt,
  input  logic                    cfg_we,
  input  logic [NEUR_W-1:0]       cfg_neur,
  input  logic [IN_W-1:0]         cfg_addr,
  input  logic [OUT_W-1:0]        cfg_wdata
`ifdef LUT_READBACK_EN
  ,
  input  logic                    cfg_re,
  output logic [OUT_W-1:0]        cfg_rdata
`endif
);

  state_t                    state, state_nxt;
  logic                      s1_valid;
  logic [N_NEUR*IN_W-1:0]    s1_data;
  logic                      s1_ready, s2_ready;
  logic [N_NEUR*OUT_W-1:0]   lookup;
  logic [N_NEUR-1:0]         tbl_we;

  // m_valid is the S2 valid flag; m_data is the S2 data register.
  assign s2_ready = !m_valid || m_ready;
  assign s1_ready = !s1_valid || s2_ready;
  assign s_ready  = (state == RUN) && s1_ready;
  assign cfg_gnt  = (state == CFG);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:     if (cfg_req) state_nxt = DRAIN;
      DRAIN: begin
        if (!cfg_req)                   state_nxt = RUN;
        else if (!s1_valid && !m_valid) state_nxt = CFG;
      end
      CFG:     if (!cfg_req) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      m_valid  <= 1'b0;
      m_data   <= '0;
    end else begin
      if (s1_ready) begin
        s1_valid <= s_valid && s_ready;
        if (s_valid && s_ready) s1_data <= s_data;
      end
      if (s2_ready) begin
        m_valid <= s1_valid;
        if (s1_valid) m_data <= lookup;
      end
    end
  end

`ifdef LUT_READBACK_EN
  logic [OUT_W-1:0] rb_data [N_NEUR];
`endif

  for (genvar k = 0; k < N_NEUR; k++) begin : g_neur
    // Out-of-range cfg_neur matches no neuron, so the write is dropped.
    assign tbl_we[k] = cfg_we && cfg_gnt && (cfg_neur == NEUR_W'(k));

    lut_neuron_table #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
    ) u_table (
      .clk   (clk),
      .we    (tbl_we[k]),
      .waddr (cfg_addr),
      .wdata (cfg_wdata),
      .raddr (s1_data[k*IN_W +: IN_W]),
      .rdata (lookup[k*OUT_W +: OUT_W])
`ifdef LUT_READBACK_EN
      ,
      .rb_addr (cfg_addr),
      .rb_data (rb_data[k])
`endif
    );
  end

`ifdef LUT_READBACK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_rdata <= '0;
    end else if (cfg_re && cfg_gnt) begin
      cfg_rdata <= (32'(cfg_neur) < N_NEUR) ? rb_data[cfg_neur] : '0;
    end
  end
`endif

endmodule
